// File: rtl/multicycle_mips_cpu_if.sv
// Unified instruction/data memory bus between the multicycle MIPS core (master)
// and the memory system (slave). A request (MemRd or MemWr) and its MemAddr stay
// stable until the rising edge on which MemReady is high.
interface multicycle_mips_cpu_if;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic        MemRd;
    logic        MemWr;
    logic [31:0] MemRData;
    logic        MemReady;

    modport master (
        output MemAddr, MemWData, MemRd, MemWr,
        input  MemRData, MemReady
    );

    modport slave (
        input  MemAddr, MemWData, MemRd, MemWr,
        output MemRData, MemReady
    );
endinterface

// File: rtl/multicycle_mips_cpu.sv
// Multicycle MIPS subset core: add, sub, and, or, slt, addi, lw, sw, beq, j, syscall.
// One shared memory port; every memory cycle waits for MemReady.
// Optional build macro MCPU_PERF_CNT_EN adds the CycleCnt/InstrCnt counters.
//
// state  | meaning
// -------+-------------------------------------------------------------
// FETCH  | MemRd at PC; on MemReady latch IR, PC += 4
// DECODE | read rs/rt into A/B, form branch target; j and syscall resolve here
// EXEC   | ALU operation; beq resolves, lw/sw compute the address
// MEM    | data read (lw) or write (sw) at the ALU result
// WB     | register-file write of ALU result or loaded data
// HALT   | terminal after syscall, no bus activity until reset
module multicycle_mips_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREG_AW  = 5
) (
    input  logic                  Clk,
    input  logic                  Reset,
    multicycle_mips_cpu_if.master mem,
    output logic [31:0]           PC,
    output logic                  Halt
`ifdef MCPU_PERF_CNT_EN
    ,
    output logic [31:0]           CycleCnt,
    output logic [31:0]           InstrCnt
`endif
);

    localparam int NREG = 1 << NREG_AW;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [31:0] SYSCALL = 32'h0000_000C;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic        halt_q, halt_d;

    logic [31:0] rf_q [NREG];
    logic               rf_we;
    logic [NREG_AW-1:0] rf_waddr;
    logic [31:0]        rf_wdata;

    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic [NREG_AW-1:0] rs_idx, rt_idx, rd_idx;
    logic [31:0]        imm_sext;
    logic [31:0]        rs_val, rt_val;
    logic [31:0]        alu_res;
    logic               alu_ok;
    logic               to_fetch;

    assign opcode   = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign rs_idx   = NREG_AW'(ir_q[25:21]);
    assign rt_idx   = NREG_AW'(ir_q[20:16]);
    assign rd_idx   = NREG_AW'(ir_q[15:11]);
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
    assign rs_val   = (rs_idx == '0) ? 32'd0 : rf_q[rs_idx];
    assign rt_val   = (rt_idx == '0) ? 32'd0 : rf_q[rt_idx];

    assign mem.MemAddr  = mem_addr_q;
    assign mem.MemWData = mem_wdata_q;
    assign mem.MemRd    = mem_rd_q;
    assign mem.MemWr    = mem_wr_q;
    assign PC           = pc_q;
    assign Halt         = halt_q;

    // ALU: R-type by funct, address/immediate add, beq compare by subtraction
    always_comb begin
        alu_res = 32'd0;
        alu_ok  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                alu_ok = 1'b1;
                case (funct)
                    FN_ADD:  alu_res = a_q + b_q;
                    FN_SUB:  alu_res = a_q - b_q;
                    FN_AND:  alu_res = a_q & b_q;
                    FN_OR:   alu_res = a_q | b_q;
                    FN_SLT:  alu_res = ($signed(a_q) < $signed(b_q)) ? 32'd1 : 32'd0;
                    default: alu_ok  = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: alu_res = a_q + imm_sext;
            OP_BEQ:                alu_res = a_q - b_q;
            default:               alu_res = 32'd0;
        endcase
    end

    // Next-state, datapath and registered bus outputs
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        alu_d       = alu_q;
        tgt_d       = tgt_q;
        mdr_d       = mdr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        halt_d      = halt_q;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = 32'd0;
        to_fetch    = 1'b0;

        case (state_q)
            FETCH: begin
                // Only right after reset is MemRd low here: launch the first fetch.
                if (!mem_rd_q) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = pc_q;
                end else if (mem.MemReady) begin
                    ir_d     = mem.MemRData;
                    pc_d     = pc_q + 32'd4;
                    mem_rd_d = 1'b0;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                a_d   = rs_val;
                b_d   = rt_val;
                tgt_d = pc_q + (imm_sext << 2);
                if (ir_q == SYSCALL) begin
                    state_d = HALT;
                    halt_d  = 1'b1;
                end else if (opcode == OP_J) begin
                    pc_d     = {pc_q[31:28], ir_q[25:0], 2'b00};
                    to_fetch = 1'b1;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_d = alu_res;
                case (opcode)
                    OP_RTYPE: begin
                        if (alu_ok) state_d  = WB;
                        else        to_fetch = 1'b1;
                    end
                    OP_ADDI: state_d = WB;
                    OP_LW: begin
                        state_d    = MEM;
                        mem_addr_d = alu_res;
                        mem_rd_d   = 1'b1;
                    end
                    OP_SW: begin
                        state_d     = MEM;
                        mem_addr_d  = alu_res;
                        mem_wdata_d = b_q;
                        mem_wr_d    = 1'b1;
                    end
                    OP_BEQ: begin
                        if (a_q == b_q) pc_d = tgt_q;
                        to_fetch = 1'b1;
                    end
                    default: to_fetch = 1'b1;
                endcase
            end
            MEM: begin
                if (mem.MemReady) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    if (opcode == OP_LW) begin
                        mdr_d   = mem.MemRData;
                        state_d = WB;
                    end else begin
                        to_fetch = 1'b1;
                    end
                end
            end
            WB: begin
                rf_we = 1'b1;
                case (opcode)
                    OP_RTYPE: begin
                        rf_waddr = rd_idx;
                        rf_wdata = alu_q;
                    end
                    OP_LW: begin
                        rf_waddr = rt_idx;
                        rf_wdata = mdr_q;
                    end
                    default: begin
                        rf_waddr = rt_idx;
                        rf_wdata = alu_q;
                    end
                endcase
                to_fetch = 1'b1;
            end
            HALT: begin
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
            end
            default: state_d = FETCH;
        endcase

        // Entering FETCH issues the next instruction read in the same edge.
        if (to_fetch) begin
            state_d    = FETCH;
            mem_rd_d   = 1'b1;
            mem_addr_d = pc_d;
        end
    end

    // FSM and datapath registers; reset aborts any bus transaction at once
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= 32'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            alu_q       <= 32'd0;
            tgt_q       <= 32'd0;
            mdr_q       <= 32'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            halt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            alu_q       <= alu_d;
            tgt_q       <= tgt_d;
            mdr_q       <= mdr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            halt_q      <= halt_d;
        end
    end

    // Register file; entry 0 is never written so it always reads zero
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= 32'd0;
        end else if (rf_we && (rf_waddr != '0)) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

`ifdef MCPU_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;

    // Cycle count skips HALT and the one launch cycle after reset; instructions
    // count on every return to FETCH
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if ((state_q != HALT) && !((state_q == FETCH) && !mem_rd_q))
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        if (to_fetch)
            instr_cnt_d = instr_cnt_q + 32'd1;
    end

    // Performance counter registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cycle_cnt_q <= 32'd0;
            instr_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign CycleCnt = cycle_cnt_q;
    assign InstrCnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_mips_cpu.sv
`timescale 1ns/1ps
module tb_multicycle_mips_cpu;

    localparam logic [5:0] OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
    localparam logic [5:0] FN_OR = 6'h25, FN_SLT = 6'h2A;
    localparam logic [31:0] SYSCALL = 32'h0000_000C;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    multicycle_mips_cpu_if bus ();
    logic [31:0] pc;
    logic        halt;
`ifdef MCPU_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    multicycle_mips_cpu #(.RESET_PC(32'h0000_0000), .NREG_AW(5)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .mem      (bus),
        .PC       (pc),
        .Halt     (halt)
`ifdef MCPU_PERF_CNT_EN
        ,
        .CycleCnt (cycle_cnt),
        .InstrCnt (instr_cnt)
`endif
    );

    // memory model: zero-wait except while a programmed stall address is accessed
    logic [31:0] mem_a [1024];
    logic        ld_en = 1'b0, ld_clr = 1'b0;
    logic [9:0]  ld_idx = '0;
    logic [31:0] ld_data = '0;
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    int          stall_amt = 0;
    int          stall_seen;
    logic        stalling;

    assign stalling     = (bus.MemRd || bus.MemWr) && (bus.MemAddr == stall_addr) && (stall_seen < stall_amt);
    assign bus.MemReady = (bus.MemRd || bus.MemWr) && !stalling;
    assign bus.MemRData = mem_a[bus.MemAddr[11:2]];

    always @(posedge Clk) begin
        if (ld_clr) begin
            for (int i = 0; i < 1024; i++) mem_a[i] <= 32'd0;
        end else if (ld_en) begin
            mem_a[ld_idx] <= ld_data;
        end else if (bus.MemWr && bus.MemReady) begin
            mem_a[bus.MemAddr[11:2]] <= bus.MemWData;
        end
    end

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) stall_seen <= 0;
        else if (stalling) stall_seen <= stall_seen + 1;
    end

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t  exp_q [$];
    int   checks = 0;
    int   failures = 0;
    logic both_seen = 1'b0;

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_store(input logic [31:0] addr, input logic [31:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // monitor: each accepted store is popped from the scoreboard and compared
    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge Clk);
            if (bus.MemRd && bus.MemWr) both_seen = 1'b1;
            if (Reset && bus.MemWr && bus.MemReady) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_store actual=0x%08h@0x%08h required=none", bus.MemWData, bus.MemAddr);
                end else begin
                    e = exp_q.pop_front();
                    check32("store_addr", bus.MemAddr, e.addr);
                    check32("store_data", bus.MemWData, e.data);
                end
            end
        end
    endtask

    task automatic begin_reset();
        Reset      = 1'b0;
        stall_amt  = 0;
        stall_addr = 32'hFFFF_FFFF;
        @(posedge Clk); #1 ld_clr = 1'b1;
        @(posedge Clk); #1 ld_clr = 1'b0;
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] data);
        ld_idx  = addr[11:2];
        ld_data = data;
        ld_en   = 1'b1;
        @(posedge Clk); #1 ld_en = 1'b0;
    endtask

    task automatic load_prog(input logic [31:0] base, input logic [31:0] words [$]);
        for (int i = 0; i < words.size(); i++) load(base + 32'(4 * i), words[i]);
    endtask

    task automatic release_reset();
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic wait_halt(input string name);
        int n;
        n = 0;
        while (!halt && n < 500) begin
            @(negedge Clk);
            n++;
        end
        check32(name, 32'(halt), 32'd1);
    endtask

    task automatic wait_first_fetch();
        for (int i = 0; i < 20 && !bus.MemRd; i++) @(negedge Clk);
    endtask

    initial begin
        logic [31:0] prog [$];
        int n, rd_cycles, hits, t0, t1, t2;
        fork
            monitor();
            begin
                #1ms;
                $display("FAIL watchdog actual=timeout required=finish");
                $fatal(1, "watchdog");
            end
        join_none

        // ---- scenario 1: addi/addi/add/sw/syscall, reset values ----
        begin_reset();
        check32("reset_pc", pc, 32'h0);
        check32("reset_memrd", 32'(bus.MemRd), 32'd0);
        check32("reset_memwr", 32'(bus.MemWr), 32'd0);
        check32("reset_halt", 32'(halt), 32'd0);
        prog = '{itype(OP_ADDI, 0, 1, 5), itype(OP_ADDI, 0, 2, 7), rtype(1, 2, 3, FN_ADD),
                 itype(OP_SW, 0, 3, 32'h40), SYSCALL};
        load_prog(32'h0, prog);
        expect_store(32'h40, 32'd12);
        release_reset();
        wait_first_fetch();
        check32("first_fetch_addr", bus.MemAddr, 32'h0);
        n = 0;
        while (!halt && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        check32("prog1_cycles", 32'(n), 32'd18);
        check32("prog1_mem40", mem_a[32'h40 >> 2], 32'd12);
        check32("prog1_pc", pc, 32'h14);
        repeat (5) @(negedge Clk);
        check32("halt_pc_frozen", pc, 32'h14);
        check32("halt_held", 32'(halt), 32'd1);
        check32("halt_no_req", 32'(bus.MemRd | bus.MemWr), 32'd0);
`ifdef MCPU_PERF_CNT_EN
        check32("perf_cycle", cycle_cnt, 32'd18);
        check32("perf_instr", instr_cnt, 32'd4);
`endif
        check32("sb_empty1", 32'(exp_q.size()), 32'd0);

        // ---- scenario 2: lw with 3 stall cycles in MEM ----
        begin_reset();
        prog = '{itype(OP_LW, 0, 4, 32'h40), itype(OP_SW, 0, 4, 32'h44), SYSCALL};
        load_prog(32'h0, prog);
        load(32'h40, 32'hDEAD_BEEF);
        stall_addr = 32'h40;
        stall_amt  = 3;
        expect_store(32'h44, 32'hDEAD_BEEF);
        release_reset();
        wait_first_fetch();
        n = 0;
        rd_cycles = 0;
        while (!(bus.MemRd && bus.MemAddr == 32'h4) && n < 100) begin
            if (bus.MemRd && bus.MemAddr == 32'h40) rd_cycles++;
            @(negedge Clk);
            n++;
        end
        check32("lw_cycles", 32'(n), 32'd8);
        check32("lw_rd_held", 32'(rd_cycles), 32'd4);
        wait_halt("lw_halt");
        check32("sb_empty2", 32'(exp_q.size()), 32'd0);

        // ---- scenario 3a: taken beq loops to itself every 3 cycles ----
        begin_reset();
        prog = '{itype(OP_ADDI, 0, 1, 3), itype(OP_BEQ, 1, 1, -1), itype(OP_SW, 0, 1, 32'h58)};
        load_prog(32'h0, prog);
        release_reset();
        wait_first_fetch();
        n = 0; hits = 0; t0 = 0; t1 = 0; t2 = 0;
        while (hits < 3 && n < 60) begin
            if (bus.MemRd && bus.MemAddr == 32'h4) begin
                if (hits == 0) t0 = n;
                else if (hits == 1) t1 = n;
                else t2 = n;
                hits++;
            end
            if (hits < 3) begin
                @(negedge Clk);
                n++;
            end
        end
        check32("beq_loop_hits", 32'(hits), 32'd3);
        check32("beq_loop_period1", 32'(t1 - t0), 32'd3);
        check32("beq_loop_period2", 32'(t2 - t1), 32'd3);
        check32("beq_loop_pc", pc, 32'h4);

        // ---- scenario 3b: untaken beq falls through ----
        begin_reset();
        prog = '{itype(OP_ADDI, 0, 1, 3), itype(OP_BEQ, 1, 0, 5), itype(OP_SW, 0, 1, 32'h50), SYSCALL};
        load_prog(32'h0, prog);
        load(32'h1C, itype(OP_SW, 0, 1, 32'h54));
        expect_store(32'h50, 32'd3);
        release_reset();
        wait_halt("beq_nt_halt");
        check32("beq_nt_pc", pc, 32'h10);
        check32("sb_empty3", 32'(exp_q.size()), 32'd0);

        // ---- scenario 4: j, $0 write discard, ALU ops, undefined NOPs ----
        begin_reset();
        load(32'h0, {OP_J, 26'h000_0100});
        prog = '{itype(OP_ADDI, 0, 0, 9), itype(OP_SW, 0, 0, 32'h60),
                 itype(OP_ADDI, 0, 6, -2), rtype(0, 6, 7, FN_SUB),
                 rtype(6, 7, 8, FN_SLT), rtype(6, 7, 9, FN_OR),
                 rtype(6, 7, 10, FN_AND), rtype(6, 7, 11, FN_ADD),
                 rtype(7, 6, 12, FN_SLT),
                 itype(OP_SW, 0, 7, 32'h64), itype(OP_SW, 0, 8, 32'h68),
                 itype(OP_SW, 0, 9, 32'h6C), itype(OP_SW, 0, 10, 32'h70),
                 itype(OP_SW, 0, 11, 32'h74), itype(OP_SW, 0, 12, 32'h78),
                 rtype(7, 7, 7, 6'h3F), 32'hFC00_0000,
                 itype(OP_SW, 0, 7, 32'h7C), SYSCALL};
        load_prog(32'h400, prog);
        expect_store(32'h60, 32'h0);
        expect_store(32'h64, 32'h2);
        expect_store(32'h68, 32'h1);
        expect_store(32'h6C, 32'hFFFF_FFFE);
        expect_store(32'h70, 32'h2);
        expect_store(32'h74, 32'h0);
        expect_store(32'h78, 32'h0);
        expect_store(32'h7C, 32'h2);
        release_reset();
        wait_first_fetch();
        n = 0;
        while (!(bus.MemRd && bus.MemAddr != 32'h0) && n < 20) begin
            @(negedge Clk);
            n++;
        end
        check32("j_target_fetch", bus.MemAddr, 32'h400);
        wait_halt("alu_halt");
        check32("alu_pc", pc, 32'h44C);
        check32("sb_empty4", 32'(exp_q.size()), 32'd0);

        // ---- scenario 5: reset during a stalled sw ----
        begin_reset();
        prog = '{itype(OP_ADDI, 0, 1, 77), itype(OP_SW, 0, 1, 32'h48), SYSCALL};
        load_prog(32'h0, prog);
        stall_addr = 32'h48;
        stall_amt  = 1000;
        release_reset();
        n = 0;
        while (!bus.MemWr && n < 40) begin
            @(negedge Clk);
            n++;
        end
        check32("sw_stall_memwr", 32'(bus.MemWr), 32'd1);
        repeat (2) @(negedge Clk);
        #2 Reset = 1'b0;
        #1;
        check32("async_memwr_drop", 32'(bus.MemWr), 32'd0);
        check32("async_pc_reset", pc, 32'h0);
        check32("async_memrd", 32'(bus.MemRd), 32'd0);
        check32("aborted_store_mem", mem_a[32'h48 >> 2], 32'd0);
        stall_amt = 0;
        @(negedge Clk);
        release_reset();
        @(negedge Clk);
        check32("restart_fetch_rd", 32'(bus.MemRd), 32'd1);
        check32("restart_fetch_addr", bus.MemAddr, 32'h0);
        check32("sb_empty5", 32'(exp_q.size()), 32'd0);
        check32("rd_wr_exclusive", 32'(both_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
